// File: rtl/multicycle_main_cu_if.sv
// Control/status bundle between the multi-cycle main control unit (master)
// and the datapath it steers (slave).
interface multicycle_main_cu_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             zero;
  logic             pc_write;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             pc_source;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, mem_ready, zero,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           state, instret
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           state, instret
  );
endinterface

// File: rtl/multicycle_main_cu.sv
// Main control FSM of the multi-cycle RV32 datapath: sequences fetch, decode,
// execute, memory and writeback for R-type/LW/SW/BEQ and traps on anything else.
module multicycle_main_cu #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_main_cu_if.master  bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_WB_R    = 4'd7,
    S_BRANCH  = 4'd8,
    S_TRAP    = 4'd9
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;

  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;
  logic       illegal_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 1'b0;
    illegal_op = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH can load it from ALUOut.
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADDR;
          OP_R:         state_next = S_EXEC_R;
          OP_BEQ:       state_next = S_BRANCH;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.opcode == OP_LW) begin
          state_next = S_MEM_RD;
        end else if (bus.opcode == OP_SW) begin
          state_next = S_MEM_WR;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 1'b1;
        pc_write   = bus.zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase

    // Reset is asynchronous, so outputs must go quiet without waiting for an edge.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.i_or_d     = i_or_d;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_source  = pc_source;
  assign bus.illegal_op = illegal_op;
  assign bus.state      = state_reg;
  assign bus.instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_main_cu.sv
// Bench for multicycle_main_cu: a table-driven instruction-sequence model checked
// every cycle against a 32-bit and a 4-bit counter instance, plus directed checks.
module tb_multicycle_main_cu;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_main_cu_if #(.CNT_W(32)) if32 ();
  multicycle_main_cu_if #(.CNT_W(4))  if4 ();

  assign if32.opcode    = opcode;
  assign if32.mem_ready = mem_ready;
  assign if32.zero      = zero;
  assign if4.opcode     = opcode;
  assign if4.mem_ready  = mem_ready;
  assign if4.zero       = zero;

  multicycle_main_cu #(.CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  multicycle_main_cu #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

  logic [13:0] act32;
  logic [13:0] act4;
  assign act32 = {if32.pc_write, if32.ir_write, if32.i_or_d, if32.mem_read, if32.mem_write,
                  if32.mem_to_reg, if32.reg_write, if32.alu_src_a, if32.alu_src_b,
                  if32.alu_op, if32.pc_source, if32.illegal_op};
  assign act4  = {if4.pc_write, if4.ir_write, if4.i_or_d, if4.mem_read, if4.mem_write,
                  if4.mem_to_reg, if4.reg_write, if4.alu_src_a, if4.alu_src_b,
                  if4.alu_op, if4.pc_source, if4.illegal_op};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Output bundle a state must present, straight from the per-state table.
  function automatic logic [13:0] exp_out(input int st, input logic mr, input logic z);
    logic pcw, irw, iod, mrd, mwr, m2r, rw, asa, psrc, ill;
    logic [1:0] asb, aop;
    {pcw, irw, iod, mrd, mwr, m2r, rw, asa, psrc, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0: begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: rw = 1;
      8: begin asa = 1; aop = 2'b01; psrc = 1; pcw = z; end
      default: ill = 1;
    endcase
    return {pcw, irw, iod, mrd, mwr, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction

  // Instruction classes as state sequences: R, LW, SW, BEQ, trap.
  int seq [5][5] = '{'{0, 1, 6, 7, 0}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
                     '{0, 1, 8, 0, 0}, '{0, 1, 9, 0, 0}};
  int seq_len [5] = '{4, 5, 4, 3, 3};

  function automatic int classify(input logic [6:0] op);
    case (op)
      OP_R:    return 0;
      OP_LW:   return 1;
      OP_SW:   return 2;
      OP_BEQ:  return 3;
      default: return 4;
    endcase
  endfunction

  int          m_cls = 0;
  int          m_idx = 0;
  logic [31:0] m_cnt = '0;

  function automatic void model_step(input int cls_i, input int idx_i, input logic [31:0] cnt_i,
                                     input logic mr, input logic [6:0] op,
                                     output int cls_o, output int idx_o, output logic [31:0] cnt_o);
    int st;
    st    = seq[cls_i][idx_i];
    cls_o = cls_i;
    idx_o = idx_i;
    cnt_o = cnt_i;
    if (st == 9) begin
      // trap is sticky
    end else if ((st == 0 || st == 3 || st == 5) && !mr) begin
      // memory access still pending
    end else if (idx_i == seq_len[cls_i] - 1) begin
      idx_o = 0;
      cnt_o = cnt_i + 1;
    end else begin
      if (idx_i == 1) cls_o = classify(op);
      idx_o = idx_i + 1;
    end
  endfunction

  always @(posedge clk) begin
    int c, i;
    logic [31:0] n;
    if (rst) begin
      m_cls <= 0;
      m_idx <= 0;
      m_cnt <= '0;
    end else begin
      model_step(m_cls, m_idx, m_cnt, mem_ready, opcode, c, i, n);
      m_cls <= c;
      m_idx <= i;
      m_cnt <= n;
    end
  end

  always @(negedge clk) begin
    int st;
    st = rst ? 0 : seq[m_cls][m_idx];
    check("state32", if32.state, st);
    check("state4", if4.state, st);
    check("outs32", act32, rst ? 14'd0 : exp_out(st, mem_ready, zero));
    check("outs4", act4, rst ? 14'd0 : exp_out(st, mem_ready, zero));
    check("instret32", if32.instret, rst ? 32'd0 : m_cnt);
    check("instret4", if4.instret, rst ? 4'd0 : m_cnt[3:0]);
  end

  task automatic cyc(input int exp_st, input string nm);
    @(negedge clk);
    check(nm, if32.state, exp_st);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1; zero = 1'b0;
    @(negedge clk);
    check("rst_state", if32.state, 0);
    check("rst_mem_read", if32.mem_read, 0);
    check("rst_ir_write", if32.ir_write, 0);
    check("rst_alu_src_b", if32.alu_src_b, 0);
    @(posedge clk); #1 rst = 1'b0;

    @(negedge clk);
    check("first_fetch_mem_read", if32.mem_read, 1);
    @(posedge clk); #1;
    cyc(1, "r_decode"); cyc(6, "r_exec"); cyc(7, "r_wb");
    check("r_instret", if32.instret, 1);
    $display("R-type   done: instret=%0d", if32.instret);

    opcode = OP_LW;
    cyc(0, "lw_fetch"); cyc(1, "lw_decode"); cyc(2, "lw_memaddr");
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("lw_wait_state", if32.state, 3);
      check("lw_wait_mem_read", if32.mem_read, 1);
      check("lw_wait_i_or_d", if32.i_or_d, 1);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    cyc(3, "lw_memrd"); cyc(4, "lw_wb");
    check("lw_instret", if32.instret, 2);
    $display("LW       done: instret=%0d", if32.instret);

    for (int b = 0; b < 2; b++) begin
      opcode = OP_BEQ;
      zero = (b == 0);
      cyc(0, "beq_fetch"); cyc(1, "beq_decode");
      @(negedge clk);
      check("beq_state", if32.state, 8);
      check("beq_pc_write", if32.pc_write, (b == 0) ? 1 : 0);
      check("beq_pc_source", if32.pc_source, 1);
      check("beq_alu_op", if32.alu_op, 1);
      @(posedge clk); #1;
      $display("BEQ z=%0d  done: instret=%0d", zero, if32.instret);
    end
    check("beq_instret", if32.instret, 4);
    zero = 1'b0;

    opcode = OP_SW;
    cyc(0, "sw_fetch"); cyc(1, "sw_decode"); cyc(2, "sw_memaddr"); cyc(5, "sw_memwr");
    check("sw_instret", if32.instret, 5);
    $display("SW       done: instret=%0d", if32.instret);

    cyc(0, "swr_fetch"); cyc(1, "swr_decode"); cyc(2, "swr_memaddr");
    mem_ready = 1'b0;
    @(negedge clk);
    check("swr_mem_write_before", if32.mem_write, 1);
    #2 rst = 1'b1;
    #1;
    check("swr_mem_write_async32", if32.mem_write, 0);
    check("swr_mem_write_async4", if4.mem_write, 0);
    check("swr_state_async", if32.state, 0);
    check("swr_instret_async", if32.instret, 0);
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1;
    $display("SW async reset done: instret=%0d", if32.instret);

    opcode = OP_BAD;
    cyc(0, "trap_fetch"); cyc(1, "trap_decode");
    repeat (20) begin
      @(negedge clk);
      check("trap_state", if32.state, 9);
      check("trap_illegal_op", if32.illegal_op, 1);
      check("trap_strobes", {if32.pc_write, if32.ir_write, if32.mem_read, if32.mem_write, if32.reg_write}, 0);
      check("trap_instret", if32.instret, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("trap_rst_state", if32.state, 0);
    check("trap_rst_illegal_op", if32.illegal_op, 0);
    @(posedge clk); #1 rst = 1'b0;
    $display("Trap     done: cleared by reset");

    opcode = OP_SW;
    for (int k = 1; k <= 16; k++) begin
      cyc(0, "wrap_fetch"); cyc(1, "wrap_decode"); cyc(2, "wrap_memaddr"); cyc(5, "wrap_memwr");
      check("wrap_instret4", if4.instret, k % 16);
      check("wrap_instret32", if32.instret, k);
      $display("SW #%0d   done: instret4=%0d instret32=%0d", k, if4.instret, if32.instret);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
